// File: rtl/updown_sweep_ctrl.sv
// rtl/updown_sweep_ctrl.sv - triangular lo->hi->lo sweep sequencer driving an up/down count
// Runs a latched number of sweeps with busy/done/err status for a host controller.
module updown_sweep_ctrl #(
  parameter int WIDTH   = 4,
  parameter int SWEEP_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               pause,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [SWEEP_W-1:0] sweeps,
  output logic [WIDTH-1:0]   count,
  output logic               upordown,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_t;

  localparam logic [SWEEP_W-1:0] ONE_SWEEP = {{(SWEEP_W-1){1'b0}}, 1'b1};

  state_t             state;
  logic [WIDTH-1:0]   lo_l;
  logic [WIDTH-1:0]   hi_l;
  logic [SWEEP_W-1:0] remaining;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      upordown  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      lo_l      <= '0;
      hi_l      <= '0;
      remaining <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (lo >= hi) begin
              err <= 1'b1;
            end else begin
              lo_l      <= lo;
              hi_l      <= hi;
              remaining <= (sweeps == '0) ? ONE_SWEEP : sweeps;
              count     <= lo;
              upordown  <= 1'b1;
              busy      <= 1'b1;
              state     <= UP;
            end
          end
        end
        UP, DOWN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (!pause) begin
            if (state == UP) begin
              // Turning at equality means count can never wrap past hi.
              if (count == hi_l) begin
                count    <= hi_l - 1'b1;
                upordown <= 1'b0;
                state    <= DOWN;
              end else begin
                count <= count + 1'b1;
              end
            end else begin
              if (count != lo_l) begin
                count <= count - 1'b1;
              end else if (remaining > ONE_SWEEP) begin
                remaining <= remaining - 1'b1;
                count     <= lo_l + 1'b1;
                upordown  <= 1'b1;
                state     <= UP;
              end else begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
- Sequencer that drives a WIDTH-bit up/down count through a programmed number of triangular sweeps: lo up to hi, then back down to lo.
- Drives the `upordown` direction line and the `count` value together, with busy/done/error status to a host controller.
- Sits between the control FSM layer and any block consuming an up/down count (PWM ramps, address sweeps).

Parameters:
- WIDTH, 4, bit width of count, lo and hi.
- SWEEP_W, 8, bit width of the sweeps request.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a sweep program; honoured only in IDLE.
- abort  input  1  terminates an active program.
- pause  input  1  level; freezes sequencing while high.
- lo  input  WIDTH  lower bound; latched at accepted start.
- hi  input  WIDTH  upper bound; latched at accepted start.
- sweeps  input  SWEEP_W  number of full sweeps; latched at accepted start; 0 is treated as 1.
- count  output  WIDTH  current count value, registered.
- upordown  output  1  current direction: 1 = counting up, 0 = counting down. Registered.
- busy  output  1  high while a program is active, including while paused.
- done  output  1  one-cycle pulse on normal completion.
- err  output  1  one-cycle pulse when start is rejected because lo >= hi.

Behaviour:
- Reset (synchronous, active-high):
  - State IDLE; count=0, upordown=1, busy=0, done=0, err=0.
  - Latched lo/hi/remaining cleared.
  - Reset takes priority over every other input, including mid-program.
- Priority while active: reset > abort > pause > normal stepping.
- States: IDLE, UP, DOWN, DONE.
- IDLE:
  - count and upordown hold their last values.
  - start=1 with lo>=hi: err=1 for the next cycle only; remain in IDLE; count unchanged.
  - start=1 with lo<hi: latch lo, hi and remaining=max(sweeps,1); count<=lo, upordown<=1, busy<=1; go to UP.
  - Latency: count=lo and busy=1 appear the cycle after start.
- UP:
  - count<hi_l: count<=count+1.
  - count==hi_l: count<=hi_l-1, upordown<=0, go to DOWN. hi is therefore visible for exactly one cycle.
- DOWN:
  - count>lo_l: count<=count-1.
  - count==lo_l with remaining>1: remaining<=remaining-1, count<=lo_l+1, upordown<=1, go to UP.
  - count==lo_l with remaining==1: go to DONE; count holds lo_l.
- DONE: done=1 and busy=0 for exactly one cycle; count=lo_l, upordown=0; then IDLE.
- Timing: busy is high for 2*(hi-lo)*N+1 cycles, where N = effective sweeps. lo appears once at each inner turnaround.
- pause=1 in UP/DOWN: count, upordown, state and remaining all freeze; busy stays 1. Stepping resumes on the first cycle pause=0.
- abort=1 in UP/DOWN, paused or not: next cycle IDLE, busy=0, done not pulsed, count and upordown hold.
- start while busy is ignored; it does not re-latch and does not raise err.
- lo, hi and sweeps changing after an accepted start have no effect on the active program.
- Arithmetic is unsigned. hi=2^WIDTH-1 and lo=0 are legal. count never wraps because the turnaround happens at equality.
- done and err are never high in the same cycle.

Test Plan:
- Reset, then start with lo=2, hi=5, sweeps=1 -> count 2,3,4,5,4,3,2 with upordown 1,1,1,1,0,0,0; then done=1/busy=0 for one cycle; count holds 2.
- lo=2, hi=5, sweeps=2 -> count 2,3,4,5,4,3,2,3,4,5,4,3,2; busy high for 13 cycles; exactly one done pulse.
- lo=0, hi=15, sweeps=0 -> one full sweep 0..15..0 with no wrap; done after 31 busy cycles.
- Start with lo=7, hi=7, then lo=9, hi=3 -> err pulses one cycle each time; busy stays 0; count unchanged.
- pause held for 3 cycles at count=4 while going up -> count stays 4 and busy stays 1; resumes at 5. abort at count=3 going down -> next cycle busy=0, no done, count holds 3.
- Mid-program: reset=1 -> next cycle count=0, upordown=1, busy=0. Start while busy -> ignored, and the sequence is identical to the unperturbed run.
